// File: rtl/reciprocal_arbiter.sv
// Round-robin sharing of one 16.16 reciprocal unit among NB_REQUESTERS valid/ready ports.
// Accept-to-response latency is RECIP_LATENCY+1 cycles; at most one op in flight per requester.
module reciprocal_arbiter #(
   parameter int NB_REQUESTERS = 4,
   parameter int RECIP_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          reset_n_i,
   input  logic [NB_REQUESTERS-1:0]      req_valid_i,
   output logic [NB_REQUESTERS-1:0]      req_ready_o,
   input  logic [32*NB_REQUESTERS-1:0]   req_x_i,
   output logic [NB_REQUESTERS-1:0]      rsp_valid_o,
   input  logic [NB_REQUESTERS-1:0]      rsp_ready_i,
   output logic [32*NB_REQUESTERS-1:0]   rsp_z_o,
   output logic [31:0]                   recip_x_o,
   output logic                          recip_valid_o,
   input  logic [31:0]                   recip_z_i
);

   localparam int IDW = $clog2(NB_REQUESTERS);
   typedef logic [IDW-1:0] id_t;

   logic [NB_REQUESTERS-1:0] busy_q, busy_d;
   logic [NB_REQUESTERS-1:0] rsp_vld_q, rsp_vld_d;
   logic [31:0]              rsp_z_q [NB_REQUESTERS];
   id_t                      rr_ptr_q, rr_ptr_d;
   logic [RECIP_LATENCY-1:0] tag_vld_q;
   id_t                      tag_id_q [RECIP_LATENCY];
   logic [31:0]              recip_x_q, recip_x_d;
   logic                     recip_vld_q;

   logic [NB_REQUESTERS-1:0] eligible;
   logic                     grant_vld;
   id_t                      grant_id;
   logic [IDW:0]             scan_idx;
   logic                     cap_vld;
   id_t                      cap_id;
   logic [NB_REQUESTERS-1:0] rsp_hs;

   // Scan from rr_ptr upward, wrapping at NB_REQUESTERS; first eligible port wins.
   always_comb begin
      eligible  = req_valid_i & ~busy_q;
      grant_vld = 1'b0;
      grant_id  = '0;
      scan_idx  = '0;
      for (int i = 0; i < NB_REQUESTERS; i++) begin
         scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
         if (scan_idx >= (IDW+1)'(NB_REQUESTERS)) begin
            scan_idx = scan_idx - (IDW+1)'(NB_REQUESTERS);
         end
         if (!grant_vld && eligible[scan_idx[IDW-1:0]]) begin
            grant_vld = 1'b1;
            grant_id  = scan_idx[IDW-1:0];
         end
      end
      req_ready_o = '0;
      if (grant_vld) begin
         req_ready_o[grant_id] = 1'b1;
      end
   end

   assign cap_vld = tag_vld_q[RECIP_LATENCY-1];
   assign cap_id  = tag_id_q[RECIP_LATENCY-1];
   assign rsp_hs  = rsp_vld_q & rsp_ready_i;

   // A granted port is never busy and a capturing port is never mid-handshake,
   // so the set/clear updates below never collide on the same bit.
   always_comb begin
      busy_d    = busy_q & ~rsp_hs;
      rsp_vld_d = rsp_vld_q & ~rsp_hs;
      rr_ptr_d  = rr_ptr_q;
      recip_x_d = recip_x_q;
      if (grant_vld) begin
         busy_d[grant_id] = 1'b1;
         recip_x_d        = req_x_i[32*grant_id +: 32];
         rr_ptr_d         = (grant_id == id_t'(NB_REQUESTERS-1)) ? '0 : grant_id + id_t'(1);
      end
      if (cap_vld) begin
         rsp_vld_d[cap_id] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         busy_q      <= '0;
         rsp_vld_q   <= '0;
         rr_ptr_q    <= '0;
         recip_x_q   <= '0;
         recip_vld_q <= 1'b0;
         tag_vld_q   <= '0;
         for (int s = 0; s < RECIP_LATENCY; s++) begin
            tag_id_q[s] <= '0;
         end
         for (int k = 0; k < NB_REQUESTERS; k++) begin
            rsp_z_q[k] <= '0;
         end
      end else begin
         busy_q       <= busy_d;
         rsp_vld_q    <= rsp_vld_d;
         rr_ptr_q     <= rr_ptr_d;
         recip_x_q    <= recip_x_d;
         recip_vld_q  <= grant_vld;
         tag_vld_q[0] <= grant_vld;
         tag_id_q[0]  <= grant_id;
         for (int s = 1; s < RECIP_LATENCY; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_id_q[s]  <= tag_id_q[s-1];
         end
         if (cap_vld) begin
            rsp_z_q[cap_id] <= recip_z_i;
         end
      end
   end

   always_comb begin
      rsp_z_o = '0;
      for (int k = 0; k < NB_REQUESTERS; k++) begin
         rsp_z_o[32*k +: 32] = rsp_z_q[k];
      end
   end

   assign rsp_valid_o   = rsp_vld_q;
   assign recip_x_o     = recip_x_q;
   assign recip_valid_o = recip_vld_q;

endmodule

// File: tb/tb_reciprocal_arbiter.sv
// Directed bench: instance A uses a combinational unit (latency 1), instance B a 3-cycle unit.
module tb_reciprocal_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reciprocal unit model: z = 256 / x in 16.16.
   function automatic logic [31:0] recip(input logic [31:0] x);
      logic [63:0] q;
      if (x == 32'd0) return 32'hFFFF_FFFF;
      q = (64'd256 << 32) / {32'd0, x};
      return q[31:0];
   endfunction

   logic             rst_a_n, rst_b_n;
   logic [N-1:0]     rv_a, rdy_a, rsv_a, rsr_a;
   logic [N-1:0]     rv_b, rdy_b, rsv_b, rsr_b;
   logic [32*N-1:0]  rx_a, rz_a, rx_b, rz_b;
   logic [31:0]      ux_a, uz_a, ux_b, uz_b;
   logic             uv_a, uv_b;
   logic [31:0]      ud1_b, ud2_b;

   assign uz_a = recip(ux_a);

   always @(posedge clk) begin
      ud1_b <= recip(ux_b);
      ud2_b <= ud1_b;
   end
   assign uz_b = ud2_b;

   reciprocal_arbiter #(.NB_REQUESTERS(N), .RECIP_LATENCY(1)) u_dut_a (
      .clk(clk), .reset_n_i(rst_a_n),
      .req_valid_i(rv_a), .req_ready_o(rdy_a), .req_x_i(rx_a),
      .rsp_valid_o(rsv_a), .rsp_ready_i(rsr_a), .rsp_z_o(rz_a),
      .recip_x_o(ux_a), .recip_valid_o(uv_a), .recip_z_i(uz_a)
   );

   reciprocal_arbiter #(.NB_REQUESTERS(N), .RECIP_LATENCY(3)) u_dut_b (
      .clk(clk), .reset_n_i(rst_b_n),
      .req_valid_i(rv_b), .req_ready_o(rdy_b), .req_x_i(rx_b),
      .rsp_valid_o(rsv_b), .rsp_ready_i(rsr_b), .rsp_z_o(rz_b),
      .recip_x_o(ux_b), .recip_valid_o(uv_b), .recip_z_i(uz_b)
   );

   logic [3:0] t2_rdy [6];
   logic       t2_rv  [6];
   logic [3:0] t2_rsv [6];
   logic [3:0] t4_rdy [6];
   logic       t4_rv  [6];
   logic [3:0] t4_rsv [6];
   int         g1;
   logic [3:0] seen;

   initial begin
      t2_rdy = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
      t2_rv  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      t2_rsv = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
      t4_rdy = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
      t4_rv  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      t4_rsv = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3};

      rst_a_n = 1'b0; rst_b_n = 1'b0;
      rv_a = '0; rx_a = '0; rsr_a = '0;
      rv_b = '0; rx_b = '0; rsr_b = '0;
      tick();
      tick();
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      #1;
      check("rst_rsp_valid", rsv_a, 4'h0);
      check("rst_recip_valid", uv_a, 1'b0);
      check("rst_recip_x", ux_a, 32'h0);
      check("rst_rsp_z", rz_a, 128'h0);
      check("rst_ready_idle", rdy_a, 4'h0);
      check("rst_b_rsp_valid", rsv_b, 4'h0);

      // single op, latency 1
      rx_a[31:0] = 32'h0002_0000;
      rv_a = 4'b0001;
      #1;
      check("t1_ready", rdy_a, 4'b0001);
      tick();
      rv_a = '0;
      #1;
      check("t1_recip_x", ux_a, 32'h0002_0000);
      check("t1_recip_valid", uv_a, 1'b1);
      check("t1_rsp_early", rsv_a, 4'h0);
      tick();
      #1;
      check("t1_rsp_valid", rsv_a, 4'b0001);
      check("t1_rsp_z", rz_a[31:0], 32'h0080_0000);
      rsr_a = 4'b0001;
      tick();
      rsr_a = '0;
      #1;
      check("t1_rsp_clear", rsv_a, 4'h0);

      // all four at once from rr_ptr = 0
      rst_a_n = 1'b0;
      #1;
      rst_a_n = 1'b1;
      rx_a = {32'h0008_0000, 32'h0004_0000, 32'h0002_0000, 32'h0001_0000};
      rv_a = 4'hF;
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("t2_ready_c%0d", i), rdy_a, t2_rdy[i]);
         check($sformatf("t2_recip_valid_c%0d", i), uv_a, t2_rv[i]);
         check($sformatf("t2_rsp_valid_c%0d", i), rsv_a, t2_rsv[i]);
         tick();
      end
      rv_a = '0;
      check("t2_rsp_z", rz_a, {32'h0020_0000, 32'h0040_0000, 32'h0080_0000, 32'h0100_0000});
      rsr_a = 4'hF;
      tick();
      rsr_a = '0;
      #1;
      check("t2_rsp_clear", rsv_a, 4'h0);

      // requester 2 stalls its response while requester 1 keeps cycling
      rx_a[95:64] = 32'h0004_0000;
      rv_a = 4'b0100;
      #1;
      check("t3_grant2", rdy_a, 4'b0100);
      tick();
      rx_a[63:32] = 32'h0002_0000;
      rv_a  = 4'b0110;
      rsr_a = 4'b0010;
      #1;
      check("t3_grant1", rdy_a, 4'b0010);
      tick();
      g1 = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         check($sformatf("t3_hold_valid_c%0d", i), rsv_a[2], 1'b1);
         check($sformatf("t3_no_grant2_c%0d", i), rdy_a[2], 1'b0);
         g1 += int'(rdy_a[1]);
         tick();
      end
      check("t3_grants_to_1", g1, 3);
      rv_a  = 4'b0100;
      rsr_a = 4'b0110;
      rx_a[95:64] = 32'h0001_0000;
      #1;
      check("t3_hs_cycle_ready", rdy_a, 4'h0);
      check("t3_hs_cycle_valid", rsv_a[2], 1'b1);
      tick();
      rsr_a = '0;
      #1;
      check("t3_after_hs_valid", rsv_a, 4'h0);
      check("t3_after_hs_grant", rdy_a, 4'b0100);
      tick();
      rv_a = '0;
      tick();
      #1;
      check("t3_new_rsp_valid", rsv_a, 4'b0100);
      check("t3_new_rsp_z", rz_a[95:64], 32'h0100_0000);
      rsr_a = 4'b0100;
      tick();
      rsr_a = '0;

      // requester 3: handshake and re-request in the same cycle
      rx_a[127:96] = 32'h0008_0000;
      rv_a = 4'b1000;
      #1;
      check("t6_first_grant", rdy_a, 4'b1000);
      tick();
      rv_a = '0;
      tick();
      rv_a  = 4'b1000;
      rx_a[127:96] = 32'h0002_0000;
      rsr_a = 4'b1000;
      #1;
      check("t6_rsp_valid", rsv_a, 4'b1000);
      check("t6_rsp_z_old", rz_a[127:96], 32'h0020_0000);
      check("t6_no_grant_hs", rdy_a, 4'h0);
      tick();
      rsr_a = '0;
      #1;
      check("t6_grant_next", rdy_a, 4'b1000);
      check("t6_valid_cleared", rsv_a, 4'h0);
      tick();
      rv_a = '0;
      tick();
      #1;
      check("t6_new_rsp_valid", rsv_a, 4'b1000);
      check("t6_new_rsp_z", rz_a[127:96], 32'h0080_0000);
      rsr_a = 4'b1000;
      tick();
      rsr_a = '0;

      // latency 3, back-to-back 0 and 1
      rx_b[31:0]  = 32'h0001_0000;
      rx_b[63:32] = 32'h0004_0000;
      rv_b = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("t4_ready_c%0d", i), rdy_b, t4_rdy[i]);
         check($sformatf("t4_recip_valid_c%0d", i), uv_b, t4_rv[i]);
         check($sformatf("t4_rsp_valid_c%0d", i), rsv_b, t4_rsv[i]);
         tick();
      end
      rv_b = '0;
      check("t4_rsp_z0", rz_b[31:0], 32'h0100_0000);
      check("t4_rsp_z1", rz_b[63:32], 32'h0040_0000);
      rsr_b = 4'b0011;
      tick();
      rsr_b = '0;

      // reset with two ops in flight
      rx_b[95:64]  = 32'h0002_0000;
      rx_b[127:96] = 32'h0008_0000;
      rv_b = 4'b1100;
      #1;
      check("t5_grant2", rdy_b, 4'b0100);
      tick();
      #1;
      check("t5_grant3", rdy_b, 4'b1000);
      tick();
      rv_b = '0;
      rst_b_n = 1'b0;
      #1;
      check("t5_rst_rsp_valid", rsv_b, 4'h0);
      check("t5_rst_recip_valid", uv_b, 1'b0);
      check("t5_rst_recip_x", ux_b, 32'h0);
      check("t5_rst_rsp_z", rz_b, 128'h0);
      tick();
      tick();
      rst_b_n = 1'b1;
      seen = '0;
      for (int i = 0; i < 6; i++) begin
         #1;
         seen = seen | rsv_b;
         tick();
      end
      check("t5_no_late_rsp", seen, 4'h0);
      rv_b = 4'b1010;
      #1;
      check("t5_first_grant", rdy_b, 4'b0010);
      tick();
      rv_b = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reciprocal_arbiter.md
Name: reciprocal_arbiter

Overview:
Shares one reciprocal unit (z = NUMERATOR/x, 16.16 fixed point) between several requesters, such as triangle setup and perspective-correct texture stages. Each requester uses a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin, with at most one issue per cycle. The block tracks in-flight operations through a tag pipeline matched to the unit's latency and returns each result to the requester that issued it.

Parameters:
NB_REQUESTERS, 4, number of requester ports (2..8).
RECIP_LATENCY, 1, cycles from recip_x_o to matching recip_z_i being sampled (>=1; 1 = combinational unit).

Ports:
clk  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
req_valid_i  in  NB_REQUESTERS  request valid, one bit per requester
req_ready_o  out  NB_REQUESTERS  request accepted this cycle (one-hot or zero)
req_x_i  in  32*NB_REQUESTERS  16.16 operand, requester k at bits [32k+31:32k]
rsp_valid_o  out  NB_REQUESTERS  result held for requester k
rsp_ready_i  in  NB_REQUESTERS  requester k consumes result
rsp_z_o  out  32*NB_REQUESTERS  16.16 result, requester k at bits [32k+31:32k]
recip_x_o  out  32  operand to shared reciprocal unit (registered)
recip_valid_o  out  1  recip_x_o carries a live operation this cycle
recip_z_i  in  32  result from shared reciprocal unit

Behaviour:
- State per requester k:
  - busy[k]: set on accept, cleared on response handshake.
  - result register rsp_z[k].
  - rsp_valid[k].
- Global state:
  - round-robin pointer rr_ptr, log2 width, range 0..NB_REQUESTERS-1.
  - tag pipeline of RECIP_LATENCY stages, each {valid, requester id}.
- Eligibility: requester k is eligible when req_valid_i[k] && !busy[k], using registered busy.
- Grant rule:
  - Grant the first eligible requester scanning k = rr_ptr, rr_ptr+1, ... modulo NB_REQUESTERS.
  - req_ready_o is combinational, and at most one bit is set.
  - req_ready_o[k] never asserts while busy[k] = 1.
- On accept of requester k at a clock edge:
  - recip_x_o <= req_x_i[k]; recip_valid_o <= 1.
  - Tag stage 0 <= {1, k}; busy[k] <= 1.
  - rr_ptr <= (k+1) mod NB_REQUESTERS.
- With no accept: recip_valid_o <= 0, recip_x_o holds its value, tag stage 0 <= invalid, rr_ptr holds.
- The tag pipeline shifts every cycle.
- The last stage, if valid with id k, captures recip_z_i into rsp_z[k] and sets rsp_valid[k] at that edge.
- recip_z_i is sampled RECIP_LATENCY-1 cycles after recip_x_o presents the operand (same cycle when RECIP_LATENCY = 1).
- Latency: a request accepted in cycle c has rsp_valid_o[k] = 1 in cycle c+1+RECIP_LATENCY.
- Throughput: one accept per cycle across requesters; one outstanding operation per requester.
- Response handshake:
  - rsp_valid_o[k] && rsp_ready_i[k] clears rsp_valid[k] and busy[k] at the edge.
  - rsp_z_o[k] holds its value until overwritten by the next capture for k.
- Simultaneous response handshake and new request for k in the same cycle: no grant to k that cycle, since busy is still set. k becomes eligible the next cycle.
- rsp_ready_i asserted while rsp_valid_o = 0: ignored.
- Capture and response handshake for the same k in the same cycle cannot occur (busy guarantees this); no priority logic is needed.
- Operand values are passed through unmodified. Zero and out-of-range handling belongs to the reciprocal unit.
- Reset (asynchronous, active-low, at any time including mid-flight):
  - busy, rsp_valid, tag valids, rr_ptr, recip_valid_o are cleared to 0.
  - recip_x_o and all rsp_z are cleared to 0.
  - In-flight operations are discarded.
  - Outputs: req_ready_o follows req_valid_i combinationally after reset release.

Test Plan:
1. RECIP_LATENCY=1, NUMERATOR=0x100, requester 0 sends x=32'h0002_0000 in cycle c -> req_ready_o=4'b0001 in cycle c; recip_x_o=32'h0002_0000 in c+1; rsp_valid_o[0]=1 with rsp_z_o[0]=32'h0080_0000 (128.0) in c+2.
2. All four requesters valid in the same cycle with rr_ptr=0 -> grants 0,1,2,3 on consecutive cycles; recip_valid_o high for 4 cycles; responses in issue order, each 2 cycles after its grant.
3. Requester 2 holds rsp_ready_i[2]=0 for 10 cycles and re-requests -> no req_ready_o[2] while rsp_valid_o[2]=1; requester 1 is still granted meanwhile; grant to 2 occurs the cycle after the response handshake.
4. RECIP_LATENCY=3, delayed bench model of the unit -> rsp_valid_o rises exactly 4 cycles after acceptance; back-to-back ops from requesters 0 and 1 land in the correct rsp_z_o slots.
5. Assert reset_n_i=0 while two operations are in flight -> all rsp_valid_o, recip_valid_o, and rsp_z_o go to 0 immediately; no response appears after release; the first grant after release goes to the lowest valid index.
6. Requester 3 has rsp_valid=1 and rsp_ready_i[3]=1 in the same cycle as req_valid_i[3]=1 -> no grant that cycle; grant next cycle; the result of the new x is captured correctly.
